helical_breath_scheduler: RTL and testbench

Round-robin scheduler that shares one `helical_nand_cell` among `N_REQ` requesters and sequences its breath cycle (inhale, hold, exhale, return) on their behalf. Each accepted request is driven through exactly one full cell cycle, and the result is returned tagged with the requester index. After any violation the scheduler pulses the cell's reset so the cell's sticky violation flag cannot leak into the next operation.

---
 rtl/helical_breath_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_helical_breath_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/helical_breath_scheduler.sv
// Round-robin scheduler sharing one helical_nand_cell among N_REQ requesters; optional lockout via HELICAL_SCHED_VIOLATION_LOCK_EN.
// Latency: gnt in cycle t -> rsp_valid in cycle t+5+HOLD_CYCLES (+1 recovery cycle after a violation).
// Backpressure: requests raised while busy simply wait; the eligible set is sampled only when idle.
module helical_breath_scheduler #(
    parameter int N_REQ       = 4,
    parameter int PHASE_BITS  = 3,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              req_signal,
    input  logic [N_REQ*PHASE_BITS-1:0]   req_phase,
    input  logic [N_REQ-1:0]              req_admit,
    output logic [N_REQ-1:0]              gnt,
    output logic                          rsp_valid,
    output logic [$clog2(N_REQ)-1:0]      rsp_id,
    output logic                          rsp_signal,
    output logic [PHASE_BITS-1:0]         rsp_phase,
    output logic                          rsp_remainder,
    output logic                          rsp_violation,
    output logic                          busy,
    output logic [N_REQ-1:0]              lock,
    input  logic [N_REQ-1:0]              lock_clr,
    output logic                          cell_rst_n,
    output logic                          cell_signal_in,
    output logic [PHASE_BITS-1:0]         cell_phase_in,
    output logic                          cell_admit,
    output logic                          cell_inhale,
    output logic                          cell_exhale,
    input  logic                          cell_signal_out,
    input  logic [PHASE_BITS-1:0]         cell_phase_out,
    input  logic                          cell_remainder,
    input  logic                          cell_violation
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHALE,
        S_HOLD,
        S_WAIT,
        S_EXHALE,
        S_CAPTURE,
        S_RECOVER
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ID_W-1:0]       last_ptr_q;
    logic [ID_W-1:0]       pick;
    logic                  found;
    logic [N_REQ-1:0]      elig;
    logic [7:0]            wait_cnt_q;
    logic                  op_signal_q;
    logic [PHASE_BITS-1:0] op_phase_q;
    logic                  op_admit_q;
    logic [N_REQ-1:0]      lock_q;

    assign elig = req & ~lock_q;

    // Round-robin search: first eligible index after last_ptr, wrapping mod N_REQ.
    always_comb begin
        pick  = last_ptr_q;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = int'(last_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && elig[idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
    end

    // Next-state and per-state strobes; grant is combinational in the idle cycle.
    always_comb begin
        state_d     = state_q;
        gnt         = '0;
        cell_inhale = 1'b0;
        cell_exhale = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rst && found) begin
                    gnt[pick] = 1'b1;
                    state_d   = S_INHALE;
                end
            end
            S_INHALE: begin
                cell_inhale = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                state_d = (HOLD_CYCLES > 0) ? S_WAIT : S_EXHALE;
            end
            S_WAIT: begin
                if (wait_cnt_q == 8'd1) begin
                    state_d = S_EXHALE;
                end
            end
            S_EXHALE: begin
                cell_exhale = 1'b1;
                state_d     = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = cell_violation ? S_RECOVER : S_IDLE;
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, arbitration pointer, operand latch and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_ptr_q  <= ID_W'(N_REQ - 1);
            wait_cnt_q  <= '0;
            op_signal_q <= 1'b0;
            op_phase_q  <= '0;
            op_admit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && found) begin
                last_ptr_q  <= pick;
                op_signal_q <= req_signal[pick];
                op_phase_q  <= req_phase[int'(pick)*PHASE_BITS +: PHASE_BITS];
                op_admit_q  <= req_admit[pick];
            end
            if (state_q == S_HOLD) begin
                wait_cnt_q <= 8'(HOLD_CYCLES);
            end else if (state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q - 8'd1;
            end
        end
    end

    // Response capture: cell outputs are sampled in S_CAPTURE and presented for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_signal    <= 1'b0;
            rsp_phase     <= '0;
            rsp_remainder <= 1'b0;
            rsp_violation <= 1'b0;
        end else begin
            rsp_valid <= (state_q == S_CAPTURE);
            if (state_q == S_CAPTURE) begin
                rsp_id        <= last_ptr_q;
                rsp_signal    <= cell_signal_out;
                rsp_phase     <= cell_phase_out;
                rsp_remainder <= cell_remainder;
                rsp_violation <= cell_violation;
            end
        end
    end

    // Cell reset: low during scheduler reset and for the single S_RECOVER cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cell_rst_n <= 1'b0;
        end else begin
            cell_rst_n <= (state_d != S_RECOVER);
        end
    end

`ifdef HELICAL_SCHED_VIOLATION_LOCK_EN
    logic [N_REQ-1:0] lock_set;

    // A violating requester is locked as its response is registered; set beats clear.
    always_comb begin
        lock_set = '0;
        if (state_q == S_CAPTURE && cell_violation) begin
            lock_set[last_ptr_q] = 1'b1;
        end
    end

    // Lockout register: clear applies the cycle after lock_clr is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= '0;
        end else begin
            lock_q <= (lock_q & ~lock_clr) | lock_set;
        end
    end
`else
    logic unused_lock_clr;

    assign lock_q          = '0;
    assign unused_lock_clr = ^lock_clr;
`endif

    assign lock           = lock_q;
    assign busy           = (state_q != S_IDLE);
    assign cell_signal_in = op_signal_q;
    assign cell_phase_in  = op_phase_q;
    assign cell_admit     = op_admit_q;

endmodule

// File: tb/tb_helical_breath_scheduler.sv
// Directed bench: two scheduler instances (HOLD_CYCLES 0 and 3) with a small behavioural cell model.
// Latency: checks are cycle-exact relative to the grant cycle.
// Backpressure: requests are held until granted; each grant wait is bounded.
module tb_helical_breath_scheduler;

`ifdef HELICAL_SCHED_VIOLATION_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_lock = 4'b0;

    // ---------------- instance A: HOLD_CYCLES = 0, driven by a cell model ----------------
    logic [3:0]  req_a = '0, req_signal_a = '0, req_admit_a = '0, lock_clr_a = '0;
    logic [11:0] req_phase_a = '0;
    logic [3:0]  gnt_a, lock_a;
    logic        rsp_valid_a, rsp_signal_a, rsp_remainder_a, rsp_violation_a, busy_a;
    logic [1:0]  rsp_id_a;
    logic [2:0]  rsp_phase_a, cell_phase_in_a, cell_phase_out_a;
    logic        cell_rst_n_a, cell_signal_in_a, cell_admit_a, cell_inhale_a, cell_exhale_a;
    logic        cell_signal_out_a, cell_remainder_a, cell_violation_a;
    logic        sticky_a = 1'b0;

    helical_breath_scheduler #(.N_REQ(4), .PHASE_BITS(3), .HOLD_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst), .req(req_a), .req_signal(req_signal_a), .req_phase(req_phase_a),
        .req_admit(req_admit_a), .gnt(gnt_a), .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a),
        .rsp_signal(rsp_signal_a), .rsp_phase(rsp_phase_a), .rsp_remainder(rsp_remainder_a),
        .rsp_violation(rsp_violation_a), .busy(busy_a), .lock(lock_a), .lock_clr(lock_clr_a),
        .cell_rst_n(cell_rst_n_a), .cell_signal_in(cell_signal_in_a), .cell_phase_in(cell_phase_in_a),
        .cell_admit(cell_admit_a), .cell_inhale(cell_inhale_a), .cell_exhale(cell_exhale_a),
        .cell_signal_out(cell_signal_out_a), .cell_phase_out(cell_phase_out_a),
        .cell_remainder(cell_remainder_a), .cell_violation(cell_violation_a)
    );

    // Cell model: phase advances by one, carry on wrap, sticky violation on inhale without admit.
    always_ff @(posedge clk) begin
        if (!cell_rst_n_a) sticky_a <= 1'b0;
        else if (cell_inhale_a && !cell_admit_a) sticky_a <= 1'b1;
    end
    assign cell_signal_out_a = cell_signal_in_a;
    assign cell_phase_out_a  = cell_phase_in_a + 3'd1;
    assign cell_remainder_a  = (cell_phase_in_a == 3'd7);
    assign cell_violation_a  = sticky_a;

    // ---------------- instance B: HOLD_CYCLES = 3, constant cell outputs ----------------
    logic [3:0]  req_b = '0;
    logic [3:0]  gnt_b, lock_b;
    logic        rsp_valid_b, rsp_signal_b, rsp_remainder_b, rsp_violation_b, busy_b;
    logic [1:0]  rsp_id_b;
    logic [2:0]  rsp_phase_b, cell_phase_in_b;
    logic        cell_rst_n_b, cell_signal_in_b, cell_admit_b, cell_inhale_b, cell_exhale_b;

    helical_breath_scheduler #(.N_REQ(4), .PHASE_BITS(3), .HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req_b), .req_signal(4'b1111), .req_phase(12'h000),
        .req_admit(4'b1111), .gnt(gnt_b), .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b),
        .rsp_signal(rsp_signal_b), .rsp_phase(rsp_phase_b), .rsp_remainder(rsp_remainder_b),
        .rsp_violation(rsp_violation_b), .busy(busy_b), .lock(lock_b), .lock_clr(4'b0000),
        .cell_rst_n(cell_rst_n_b), .cell_signal_in(cell_signal_in_b), .cell_phase_in(cell_phase_in_b),
        .cell_admit(cell_admit_b), .cell_inhale(cell_inhale_b), .cell_exhale(cell_exhale_b),
        .cell_signal_out(1'b1), .cell_phase_out(3'd5), .cell_remainder(1'b0), .cell_violation(1'b0)
    );

    typedef struct {
        logic [3:0] req;
        logic       sig;
        logic [2:0] ph;
        logic       adm;
        int         id;
        logic       esig;
        logic [2:0] eph;
        logic       erem;
        logic       eviol;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_a = '0; req_b = '0; exp_lock = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One full operation on instance A with cycle-exact strobe checks.
    task automatic op_a(input vec_t v);
        int wc;
        logic [6:0] inh, exh, vld, rstn;
        @(negedge clk);
        req_a = v.req; req_signal_a = {4{v.sig}}; req_phase_a = {4{v.ph}}; req_admit_a = {4{v.adm}};
        #1;
        wc = 0;
        while (gnt_a == 4'b0 && wc < 20) begin
            @(negedge clk); #1; wc++;
        end
        chk("gnt", gnt_a, 32'(1 << v.id));
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) req_a = '0;
            #1;
            inh[k-1]  = cell_inhale_a;
            exh[k-1]  = cell_exhale_a;
            vld[k-1]  = rsp_valid_a;
            rstn[k-1] = cell_rst_n_a;
            if (k == 1) begin
                chk("busy", busy_a, 1);
                chk("cell_signal_in", cell_signal_in_a, v.sig);
                chk("cell_phase_in", cell_phase_in_a, v.ph);
                chk("cell_admit", cell_admit_a, v.adm);
            end
            if (k == 5) begin
                if (LOCK_EN && v.eviol) exp_lock = exp_lock | 4'(1 << v.id);
                chk("rsp_id", rsp_id_a, v.id);
                chk("rsp_signal", rsp_signal_a, v.esig);
                chk("rsp_phase", rsp_phase_a, v.eph);
                chk("rsp_remainder", rsp_remainder_a, v.erem);
                chk("rsp_violation", rsp_violation_a, v.eviol);
                chk("lock", lock_a, exp_lock);
            end
        end
        chk("inhale_timing", inh, 7'b0000001);
        chk("exhale_timing", exh, 7'b0000100);
        chk("rsp_valid_timing", vld, 7'b0010000);
        chk("cell_rst_n_timing", rstn, v.eviol ? 7'b1101111 : 7'b1111111);
    endtask

    vec_t vecs[7];
    int gid[8], gcyc[8], rid[8];
    int ng, nr, cyc, wc, nv;
    logic [8:0] exh9, vld9;

    initial begin
        //            req      sig  ph    adm  id  esig  eph   erem  eviol
        vecs[0] = '{4'b0001, 1'b1, 3'd3, 1'b1, 0, 1'b1, 3'd4, 1'b0, 1'b0};
        vecs[1] = '{4'b0100, 1'b0, 3'd7, 1'b1, 2, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[2] = '{4'b1001, 1'b1, 3'd5, 1'b1, 3, 1'b1, 3'd6, 1'b0, 1'b0};
        vecs[3] = '{4'b1001, 1'b0, 3'd1, 1'b1, 0, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[4] = '{4'b0010, 1'b1, 3'd2, 1'b0, 1, 1'b1, 3'd3, 1'b0, 1'b1};
        vecs[5] = '{4'b0001, 1'b1, 3'd0, 1'b1, 0, 1'b1, 3'd1, 1'b0, 1'b0};
        vecs[6] = '{4'b1100, 1'b0, 3'd6, 1'b1, 2, 1'b0, 3'd7, 1'b0, 1'b0};

        // Reset state, with a request pending to show no grant leaks out during reset.
        req_a = 4'b0001;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", gnt_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_rsp_valid", rsp_valid_a, 0);
        chk("rst_rsp_phase", rsp_phase_a, 0);
        chk("rst_cell_rst_n", cell_rst_n_a, 0);
        chk("rst_inhale_exhale", {cell_inhale_a, cell_exhale_a}, 0);
        chk("rst_lock", lock_a, 0);
        chk("rst_operands", {cell_signal_in_a, cell_phase_in_a, cell_admit_a}, 0);
        @(negedge clk);
        rst = 1'b0; req_a = '0;
        @(negedge clk); #1;
        chk("cell_rst_n_release", cell_rst_n_a, 1);

        // All requests held high: grants and responses rotate 0,1,2,3,0 every 5 cycles.
        @(negedge clk);
        req_a = 4'hF; req_signal_a = 4'hF; req_phase_a = '0; req_admit_a = 4'hF;
        #1;
        ng = 0; nr = 0; cyc = 0;
        while (ng < 5 && cyc < 40) begin
            if (gnt_a != 4'b0) begin gid[ng] = oh2i(gnt_a); gcyc[ng] = cyc; ng++; end
            if (rsp_valid_a) begin rid[nr] = int'(rsp_id_a); nr++; end
            @(negedge clk); #1; cyc++;
        end
        req_a = '0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid_a && nr < 8) begin rid[nr] = int'(rsp_id_a); nr++; end
            @(negedge clk); #1;
        end
        chk("rr_grant_count", ng, 5);
        for (int k = 0; k < ng; k++) chk("rr_grant_order", gid[k], k % 4);
        for (int k = 1; k < ng; k++) chk("rr_grant_spacing", gcyc[k] - gcyc[k-1], 5);
        chk("rr_rsp_count", nr, 5);
        for (int k = 0; k < nr && k < 5; k++) chk("rr_rsp_order", rid[k], k % 4);

        // Table of single operations, including a violation and the recovery after it.
        do_reset();
        for (int i = 0; i < 7; i++) op_a(vecs[i]);

`ifdef HELICAL_SCHED_VIOLATION_LOCK_EN
        // Lockout: requester 2 violates, is skipped while locked, then granted after lock_clr.
        do_reset();
        op_a('{4'b0010, 1'b1, 3'd0, 1'b1, 1, 1'b1, 3'd1, 1'b0, 1'b0});
        op_a('{4'b0100, 1'b1, 3'd0, 1'b0, 2, 1'b1, 3'd1, 1'b0, 1'b1});
        @(negedge clk);
        req_a = 4'b0100; req_admit_a = 4'hF;
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            #1; if (gnt_a != 4'b0) ng++;
            @(negedge clk);
        end
        chk("locked_no_grant", ng, 0);
        lock_clr_a = 4'b0100;
        @(negedge clk);
        lock_clr_a = 4'b0000;
        #1;
        chk("lock_cleared", lock_a, 0);
        wc = 0;
        while (gnt_a == 4'b0 && wc < 10) begin @(negedge clk); #1; wc++; end
        chk("unlocked_grant", gnt_a, 4'b0100);
        @(negedge clk);
        req_a = '0;
        repeat (8) @(negedge clk);
`endif

        // Stretched hold on instance B: exhale at t+6, rsp_valid at t+8.
        do_reset();
        @(negedge clk);
        req_b = 4'b0010;
        #1;
        wc = 0;
        while (gnt_b == 4'b0 && wc < 20) begin @(negedge clk); #1; wc++; end
        chk("hold_gnt", gnt_b, 4'b0010);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) req_b = '0;
            #1;
            exh9[k-1] = cell_exhale_b;
            vld9[k-1] = rsp_valid_b;
            if (k == 8) begin
                chk("hold_rsp_id", rsp_id_b, 1);
                chk("hold_rsp_phase", rsp_phase_b, 5);
            end
        end
        chk("hold_exhale_timing", exh9, 9'b000100000);
        chk("hold_rsp_valid_timing", vld9, 9'b010000000);

        // Reset during S_WAIT: no response, cell held in reset, pointer restarts at requester 0.
        @(negedge clk);
        req_b = 4'b0001;
        #1;
        wc = 0;
        while (gnt_b == 4'b0 && wc < 20) begin @(negedge clk); #1; wc++; end
        chk("abort_gnt", gnt_b, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req_b = '0;
        end
        #1;
        chk("abort_busy_before", busy_b, 1);
        rst = 1'b1; exp_lock = '0;
        @(negedge clk); #1;
        chk("abort_busy", busy_b, 0);
        chk("abort_cell_rst_n_b", cell_rst_n_b, 0);
        chk("abort_cell_rst_n_a", cell_rst_n_a, 0);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            #1; if (rsp_valid_b) nv++;
            @(negedge clk);
        end
        chk("abort_no_rsp", nv, 0);
        chk("abort_cell_rst_n_after", cell_rst_n_b, 1);
        req_b = 4'b0011;
        #1;
        wc = 0;
        while (gnt_b == 4'b0 && wc < 20) begin @(negedge clk); #1; wc++; end
        chk("abort_first_gnt", gnt_b, 4'b0001);
        @(negedge clk);
        req_b = '0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
